// File: rtl/mux_scan_seq.sv
// Registered N-channel, W-bit multiplexer with a direct-select mode and an
// autonomous scan mode that visits the masked channels, each for dwell+1 cycles.
module mux_scan_seq #(
    parameter int NCH     = 16,
    parameter int W       = 1,
    parameter int SELW    = $clog2(NCH),
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NCH*W-1:0]   in,
    input  logic [SELW-1:0]    sel,
    input  logic               mode,
    input  logic               en,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [NCH-1:0]     mask,
    output logic [W-1:0]       out,
    output logic [SELW-1:0]    out_ch,
    output logic               out_valid,
    output logic               wrap
);

    typedef enum logic {ST_DIRECT = 1'b0, ST_SCAN = 1'b1} state_t;

    localparam logic [SELW:0] NCH_V = (SELW+1)'(NCH);

    state_t               state_q, state_d;
    logic [SELW-1:0]      cur_ch_q, cur_ch_d;
    logic [DWELL_W-1:0]   dcnt_q, dcnt_d;
    logic                 pend_q, pend_d;
    logic [W-1:0]         out_q, out_d;
    logic [SELW-1:0]      out_ch_q, out_ch_d;
    logic                 out_valid_q, out_valid_d;
    logic                 wrap_q, wrap_d;

    logic [SELW-1:0]      lowest_s, eff_s, next_s;
    logic [DWELL_W-1:0]   base_s;
    logic                 cur_in_mask_s;

    function automatic logic [SELW-1:0] lowest_set(input logic [NCH-1:0] m);
        lowest_set = {SELW{1'b0}};
        for (int i = NCH-1; i >= 0; i--) begin
            if (m[i]) lowest_set = SELW'(i);
        end
    endfunction

    // Next set bit strictly above c, falling back to the lowest set bit (circular).
    function automatic logic [SELW-1:0] next_set(input logic [NCH-1:0] m, input logic [SELW-1:0] c);
        next_set = lowest_set(m);
        for (int i = NCH-1; i >= 0; i--) begin
            if (m[i] && (SELW'(i) > c)) next_set = SELW'(i);
        end
    endfunction

    // Next-state and next-output computation for both modes.
    always_comb begin
        state_d       = state_q;
        cur_ch_d      = cur_ch_q;
        dcnt_d        = dcnt_q;
        pend_d        = pend_q;
        out_d         = out_q;
        out_ch_d      = out_ch_q;
        out_valid_d   = 1'b0;
        wrap_d        = 1'b0;

        // A channel dropped from the mask is replaced by its successor and restarts its dwell.
        cur_in_mask_s = mask[cur_ch_q];
        lowest_s      = lowest_set(mask);
        eff_s         = cur_in_mask_s ? cur_ch_q : next_set(mask, cur_ch_q);
        base_s        = cur_in_mask_s ? dcnt_q : {DWELL_W{1'b0}};
        next_s        = next_set(mask, eff_s);

        if (!en) begin
            out_valid_d = 1'b0;
        end else if (!mode) begin
            state_d  = ST_DIRECT;
            cur_ch_d = {SELW{1'b0}};
            dcnt_d   = {DWELL_W{1'b0}};
            pend_d   = 1'b0;
            out_ch_d = sel;
            if ({1'b0, sel} < NCH_V) begin
                out_d       = in[int'(sel)*W +: W];
                out_valid_d = 1'b1;
            end else begin
                out_d       = {W{1'b0}};
                out_valid_d = 1'b0;
            end
        end else if (state_q == ST_DIRECT) begin
            state_d  = ST_SCAN;
            cur_ch_d = lowest_s;
            dcnt_d   = {DWELL_W{1'b0}};
            pend_d   = 1'b0;
        end else if (mask == {NCH{1'b0}}) begin
            out_valid_d = 1'b0;
        end else begin
            out_d       = in[int'(eff_s)*W +: W];
            out_ch_d    = eff_s;
            out_valid_d = 1'b1;
            wrap_d      = pend_q | (!cur_in_mask_s && (eff_s <= cur_ch_q));
            pend_d      = 1'b0;
            if (base_s >= dwell) begin
                cur_ch_d = next_s;
                dcnt_d   = {DWELL_W{1'b0}};
                pend_d   = (next_s <= eff_s);
            end else begin
                cur_ch_d = eff_s;
                dcnt_d   = base_s + DWELL_W'(1);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_DIRECT;
            cur_ch_q    <= {SELW{1'b0}};
            dcnt_q      <= {DWELL_W{1'b0}};
            pend_q      <= 1'b0;
            out_q       <= {W{1'b0}};
            out_ch_q    <= {SELW{1'b0}};
            out_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_ch_q    <= cur_ch_d;
            dcnt_q      <= dcnt_d;
            pend_q      <= pend_d;
            out_q       <= out_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            wrap_q      <= wrap_d;
        end
    end

    assign out       = out_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Bench for mux_scan_seq: directed vector tables, hand-written multi-cycle
// sequences, and randomized traffic against a behavioural reference model.
module tb_mux_scan_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_s;
    logic [3:0]  sel_s;
    logic        mode_s, en_s;
    logic [7:0]  dwell_s;
    logic [15:0] mask_s;
    logic        out_o;
    logic [3:0]  out_ch_o;
    logic        out_valid_o, wrap_o;

    logic [39:0] in5_s;
    logic [7:0]  out5_o;
    logic [2:0]  out5_ch_o;
    logic        out5_valid_o, wrap5_o;

    int n_chk = 0;
    int n_fail = 0;
    bit rnd_chk = 1'b0;

    // reference model state
    bit   m_scan, m_due;
    int   m_ch, m_cnt;
    logic e_out, e_valid, e_wrap;
    logic [3:0] e_ch;

    always #5 clk = ~clk;

    mux_scan_seq #(.NCH(16), .W(1), .SELW(4), .DWELL_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in(in_s), .sel(sel_s), .mode(mode_s), .en(en_s),
        .dwell(dwell_s), .mask(mask_s), .out(out_o), .out_ch(out_ch_o),
        .out_valid(out_valid_o), .wrap(wrap_o));

    mux_scan_seq #(.NCH(5), .W(8), .SELW(3), .DWELL_W(8)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .in(in5_s), .sel(sel_s[2:0]), .mode(mode_s), .en(en_s),
        .dwell(dwell_s), .mask(mask_s[4:0]), .out(out5_o), .out_ch(out5_ch_o),
        .out_valid(out5_valid_o), .wrap(wrap5_o));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Next included channel after c, walking upward modulo 16.
    task automatic m_next(input int c, input logic [15:0] m, output int n, output bit wrapped);
        n = c;
        wrapped = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            if (m[(c + k) % 16]) begin
                n = (c + k) % 16;
                wrapped = ((c + k) >= 16);
                break;
            end
        end
    endtask

    task automatic model_reset();
        m_scan = 0; m_due = 0; m_ch = 0; m_cnt = 0;
        e_out = 1'b0; e_ch = 4'd0; e_valid = 1'b0; e_wrap = 1'b0;
    endtask

    task automatic model_step();
        int  c, used, n;
        bit  w, wr;
        if (!en_s) begin
            e_valid = 1'b0; e_wrap = 1'b0;
        end else if (!mode_s) begin
            m_scan = 0; m_due = 0; m_ch = 0; m_cnt = 0;
            e_ch = sel_s; e_out = in_s[sel_s]; e_valid = 1'b1; e_wrap = 1'b0;
        end else if (!m_scan) begin
            m_scan = 1; m_due = 0; m_cnt = 0; m_ch = 0;
            for (int k = 15; k >= 0; k--) if (mask_s[k]) m_ch = k;
            e_valid = 1'b0; e_wrap = 1'b0;
        end else if (mask_s == 16'h0000) begin
            e_valid = 1'b0; e_wrap = 1'b0;
        end else begin
            c = m_ch; used = m_cnt; w = m_due;
            if (!mask_s[c]) begin
                m_next(c, mask_s, n, wr);
                w = w | wr; c = n; used = 0;
            end
            e_ch = 4'(c); e_out = in_s[c]; e_valid = 1'b1; e_wrap = w;
            m_due = 0;
            if (used >= int'(dwell_s)) begin
                m_next(c, mask_s, n, wr);
                m_ch = n; m_cnt = 0; m_due = wr;
            end else begin
                m_ch = c; m_cnt = used + 1;
            end
        end
    endtask

    // One clock: model consumes the inputs the DUT samples, outputs read on the falling edge.
    task automatic cyc();
        model_step();
        @(posedge clk);
        @(negedge clk);
        if (rnd_chk) begin
            chk("rnd_out", 32'(out_o), 32'(e_out));
            chk("rnd_ch", 32'(out_ch_o), 32'(e_ch));
            chk("rnd_valid", 32'(out_valid_o), 32'(e_valid));
            chk("rnd_wrap", 32'(wrap_o), 32'(e_wrap));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mode_s = 1'b0; en_s = 1'b1; sel_s = 4'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct { logic [3:0] sel; logic exp_out; } dvec_t;
    typedef struct { logic [3:0] ch; logic wr; } svec_t;

    dvec_t dv[5];
    svec_t sv2[12];
    svec_t sv3[4];

    initial begin
        dv[0] = '{4'd3, 1'b1};  dv[1] = '{4'd0, 1'b1};  dv[2] = '{4'd5, 1'b1};
        dv[3] = '{4'd12, 1'b1}; dv[4] = '{4'd2, 1'b0};
        for (int i = 0; i < 12; i++) begin
            sv2[i].ch = ((i % 6) < 3) ? 4'd0 : 4'd4;
            sv2[i].wr = (i == 6) ? 1'b1 : 1'b0;
        end
        sv3[0] = '{4'd0, 1'b0};  sv3[1] = '{4'd15, 1'b0};
        sv3[2] = '{4'd0, 1'b1};  sv3[3] = '{4'd15, 1'b0};

        rst_n = 1'b0;
        in_s = 16'h0000; in5_s = 40'h0; sel_s = 4'd0; mode_s = 1'b0; en_s = 1'b1;
        dwell_s = 8'd0; mask_s = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out", 32'(out_o), 32'd0);
        chk("rst_ch", 32'(out_ch_o), 32'd0);
        chk("rst_valid", 32'(out_valid_o), 32'd0);
        chk("rst_wrap", 32'(wrap_o), 32'd0);
        rst_n = 1'b1;
        model_reset();

        // direct mode vectors
        in_s = 16'h30ab;
        for (int i = 0; i < 5; i++) begin
            sel_s = dv[i].sel;
            cyc();
            chk("dir_out", 32'(out_o), 32'(dv[i].exp_out));
            chk("dir_ch", 32'(out_ch_o), 32'(dv[i].sel));
            chk("dir_valid", 32'(out_valid_o), 32'd1);
        end

        // scan mask 0x0011 dwell 2
        do_reset();
        in_s = 16'h0010; mask_s = 16'h0011; dwell_s = 8'd2; mode_s = 1'b1;
        cyc();
        chk("scan_entry_valid", 32'(out_valid_o), 32'd0);
        for (int i = 0; i < 12; i++) begin
            cyc();
            chk("scan2_ch", 32'(out_ch_o), 32'(sv2[i].ch));
            chk("scan2_wrap", 32'(wrap_o), 32'(sv2[i].wr));
            chk("scan2_out", 32'(out_o), (sv2[i].ch == 4'd4) ? 32'd1 : 32'd0);
            chk("scan2_valid", 32'(out_valid_o), 32'd1);
        end

        // scan dwell 0 mask 0x8001, then empty mask
        do_reset();
        in_s = 16'h8000; mask_s = 16'h8001; dwell_s = 8'd0; mode_s = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("scan3_ch", 32'(out_ch_o), 32'(sv3[i].ch));
            chk("scan3_wrap", 32'(wrap_o), 32'(sv3[i].wr));
        end
        mask_s = 16'h0000; in_s = 16'h0000;
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("mask0_valid", 32'(out_valid_o), 32'd0);
            chk("mask0_ch", 32'(out_ch_o), 32'd15);
            chk("mask0_out", 32'(out_o), 32'd1);
        end

        // en low mid-dwell freezes and resumes the count
        do_reset();
        in_s = 16'h0001; mask_s = 16'h0011; dwell_s = 8'd2; mode_s = 1'b1;
        cyc();
        cyc();
        chk("en_pre_ch", 32'(out_ch_o), 32'd0);
        en_s = 1'b0; in_s = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("en_lo_valid", 32'(out_valid_o), 32'd0);
            chk("en_lo_ch", 32'(out_ch_o), 32'd0);
            chk("en_lo_out", 32'(out_o), 32'd1);
        end
        en_s = 1'b1;
        cyc(); chk("en_res_ch0", 32'(out_ch_o), 32'd0);
        cyc(); chk("en_res_ch1", 32'(out_ch_o), 32'd0);
        cyc(); chk("en_res_ch2", 32'(out_ch_o), 32'd4);

        // mode switch out of and back into scan
        do_reset();
        in_s = 16'h0080; mask_s = 16'h0011; dwell_s = 8'd0; mode_s = 1'b1;
        cyc(); cyc(); cyc();
        chk("ms_scan_ch", 32'(out_ch_o), 32'd4);
        mode_s = 1'b0; sel_s = 4'd7;
        cyc();
        chk("ms_dir_ch", 32'(out_ch_o), 32'd7);
        chk("ms_dir_out", 32'(out_o), 32'd1);
        mode_s = 1'b1;
        cyc();
        chk("ms_entry_valid", 32'(out_valid_o), 32'd0);
        cyc();
        chk("ms_restart_ch", 32'(out_ch_o), 32'd0);
        chk("ms_restart_wrap", 32'(wrap_o), 32'd0);

        // 5-channel byte-wide instance
        do_reset();
        in5_s = 40'h55_44_33_22_11; sel_s = 4'd6;
        cyc();
        chk("w8_bad_out", 32'(out5_o), 32'd0);
        chk("w8_bad_valid", 32'(out5_valid_o), 32'd0);
        chk("w8_bad_ch", 32'(out5_ch_o), 32'd6);
        sel_s = 4'd3;
        cyc();
        chk("w8_ok_out", 32'(out5_o), 32'h44);
        chk("w8_ok_valid", 32'(out5_valid_o), 32'd1);

        // asynchronous reset mid-scan
        in_s = 16'hffff; mask_s = 16'h0010; dwell_s = 8'd3; mode_s = 1'b1;
        cyc(); cyc();
        chk("pre_arst_ch", 32'(out_ch_o), 32'd4);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out", 32'(out_o), 32'd0);
        chk("arst_ch", 32'(out_ch_o), 32'd0);
        chk("arst_valid", 32'(out_valid_o), 32'd0);
        chk("arst_wrap", 32'(wrap_o), 32'd0);
        chk("arst5_ch", 32'(out5_ch_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // randomized traffic against the reference model
        mode_s = 1'b0; en_s = 1'b1; dwell_s = 8'd1; mask_s = 16'h0421;
        rnd_chk = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            in_s  = 16'($urandom);
            sel_s = 4'($urandom_range(0, 15));
            en_s  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 24) == 0) mode_s = ~mode_s;
            if ($urandom_range(0, 14) == 0) dwell_s = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0)
                mask_s = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom & $urandom);
            cyc();
        end
        rnd_chk = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
